serpent_dec_ctrl: RTL and testbench

SERPENT_DEC_CTRL -- requirements
Module: serpent_dec_ctrl

---
 rtl/serpent_dec_ctrl.sv | 177 +++++++++++++++++
 tb/tb_serpent_dec_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serpent_dec_ctrl.sv
// Serpent decryption sequencer: one inverse round per cycle, round keys fetched from an external store.
// Defining SERPENT_DEC_ABORT_EN adds the i_abort port.

module serpent_dec_ctrl (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_data,
    output logic         o_busy,
    output logic [5:0]   o_rk_idx,
    input  logic [127:0] i_rk,
    input  logic         i_rk_vld,
    output logic [127:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
`ifdef SERPENT_DEC_ABORT_EN
    ,
    input  logic         i_abort
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEY32 = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t       state_r, state_s;
    logic [127:0] data_r, data_s;
    logic [4:0]   round_r, round_s;
    logic         abort_s;
    logic [127:0] sbox_in_s, round_out_s;

    // Inverse S-box tables, entry x held in nibble x (entry 0 in the LSBs).
    function automatic logic [3:0] inv_sbox_nib(input logic [2:0] k, input logic [3:0] x);
        logic [63:0] tbl;
        case (k)
            3'd0:    tbl = 64'h289F_74E1_C56A_0B3D;
            3'd1:    tbl = 64'h0AD1_974B_3C6F_E285;
            3'd2:    tbl = 64'h7A85_D630_21EB_4F9C;
            3'd3:    tbl = 64'h1F84_2C53_D6EB_7A90;
            3'd4:    tbl = 64'h1DF4_6BC2_E79A_3805;
            3'd5:    tbl = 64'h0AC7_356B_ED14_92F8;
            3'd6:    tbl = 64'hB8C2_7E94_0635_D1AF;
            3'd7:    tbl = 64'h241A_7BC5_8FE9_D603;
            default: tbl = 64'h0;
        endcase
        return tbl[{x, 2'b00} +: 4];
    endfunction

    // Bitsliced: column j is {X3[j],X2[j],X1[j],X0[j]}, X0 = bits 127:96.
    function automatic logic [127:0] inv_sbox(input logic [2:0] k, input logic [127:0] s);
        logic [127:0] y;
        logic [3:0]   v;
        y = 128'h0;
        for (int j = 0; j < 32; j++) begin
            v = inv_sbox_nib(k, {s[j], s[32+j], s[64+j], s[96+j]});
            y[96+j] = v[0];
            y[64+j] = v[1];
            y[32+j] = v[2];
            y[j]    = v[3];
        end
        return y;
    endfunction

    // Inverse linear transform; undoes the forward mixing steps in reverse order.
    function automatic logic [127:0] lt_inv(input logic [127:0] s);
        logic [31:0] a0, a1, a2, a3, c0, c2, d1, d3, e1, e3, f0, f2;
        a0 = s[127:96];
        a1 = s[95:64];
        a2 = s[63:32];
        a3 = s[31:0];
        c2 = {a2[21:0], a2[31:22]} ^ a3 ^ (a1 << 7);
        c0 = {a0[4:0], a0[31:5]} ^ a1 ^ a3;
        d3 = {a3[6:0], a3[31:7]};
        d1 = {a1[0], a1[31:1]};
        e3 = d3 ^ c2 ^ (c0 << 3);
        e1 = d1 ^ c0 ^ c2;
        f2 = {c2[2:0], c2[31:3]};
        f0 = {c0[12:0], c0[31:13]};
        return {f0, e1, f2, e3};
    endfunction

`ifdef SERPENT_DEC_ABORT_EN
    assign abort_s = i_abort;
`else
    assign abort_s = 1'b0;
`endif

    // Round 31 skips the linear transform; every other round applies it first.
    assign sbox_in_s   = (round_r == 5'd31) ? data_r : lt_inv(data_r);
    assign round_out_s = inv_sbox(round_r[2:0], sbox_in_s) ^ i_rk;

    // State, data and round-counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
            data_r  <= 128'h0;
            round_r <= 5'd0;
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            round_r <= round_s;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        round_s = round_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    data_s  = i_data;
                    state_s = KEY32;
                end else begin
                    state_s = IDLE;
                end
            end
            KEY32: begin
                if (i_rk_vld) begin
                    data_s  = data_r ^ i_rk;
                    round_s = 5'd31;
                    state_s = RUN;
                end else begin
                    state_s = KEY32;
                end
            end
            RUN: begin
                if (i_rk_vld) begin
                    data_s = round_out_s;
                    if (round_r == 5'd0) begin
                        state_s = DONE;
                    end else begin
                        round_s = round_r - 5'd1;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        if (abort_s && (state_r != IDLE)) begin
            state_s = IDLE;
            data_s  = 128'h0;
            round_s = 5'd0;
        end else begin
            round_s = round_s;
        end
    end

    // Output decode, driven purely from registered state.
    always_comb begin
        o_data  = data_r;
        o_busy  = (state_r != IDLE);
        o_valid = (state_r == DONE);
        case (state_r)
            IDLE:    o_rk_idx = 6'd0;
            KEY32:   o_rk_idx = 6'd32;
            RUN:     o_rk_idx = {1'b0, round_r};
            DONE:    o_rk_idx = 6'd0;
            default: o_rk_idx = 6'd0;
        endcase
    end

endmodule

// File: tb/tb_serpent_dec_ctrl.sv
// Bench for serpent_dec_ctrl: expected plaintexts come from an independent forward
// Serpent model (key schedule + encryption); the DUT must invert it.

module tb_serpent_dec_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] data;
    logic         busy;
    logic [5:0]   rk_idx;
    logic [127:0] rk;
    logic         rk_vld;
    logic [127:0] dout;
    logic         valid;
    logic         ready;
`ifdef SERPENT_DEC_ABORT_EN
    logic         abort;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [127:0] rk_tbl [0:32];

    int unsigned sb_fwd [0:7][0:15] = '{
        '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
        '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
        '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
        '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
        '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
        '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
        '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
        '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
    };

    serpent_dec_ctrl dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_data   (data),
        .o_busy   (busy),
        .o_rk_idx (rk_idx),
        .i_rk     (rk),
        .i_rk_vld (rk_vld),
        .o_data   (dout),
        .o_valid  (valid),
        .i_ready  (ready)
`ifdef SERPENT_DEC_ABORT_EN
        ,
        .i_abort  (abort)
`endif
    );

    always #5 clk = ~clk;

    // External key store: combinational lookup of the requested round key.
    assign rk = (rk_idx <= 6'd32) ? rk_tbl[rk_idx] : 128'h0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] a, input int n);
        return (a << n) | (a >> (32 - n));
    endfunction

    function automatic logic [127:0] sbox_fwd(input int k, input logic [127:0] x);
        logic [127:0] y;
        int unsigned  v;
        y = 128'h0;
        for (int j = 0; j < 32; j++) begin
            v = sb_fwd[k][{x[j], x[32+j], x[64+j], x[96+j]}];
            y[96+j] = v[0];
            y[64+j] = v[1];
            y[32+j] = v[2];
            y[j]    = v[3];
        end
        return y;
    endfunction

    function automatic logic [127:0] lt_fwd(input logic [127:0] x);
        logic [31:0] x0, x1, x2, x3;
        x0 = x[127:96]; x1 = x[95:64]; x2 = x[63:32]; x3 = x[31:0];
        x0 = rotl(x0, 13);
        x2 = rotl(x2, 3);
        x1 = x1 ^ x0 ^ x2;
        x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = rotl(x1, 1);
        x3 = rotl(x3, 7);
        x0 = x0 ^ x1 ^ x3;
        x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = rotl(x0, 5);
        x2 = rotl(x2, 22);
        return {x0, x1, x2, x3};
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] p);
        logic [127:0] b;
        b = p;
        for (int i = 0; i < 32; i++) begin
            b = sbox_fwd(i % 8, b ^ rk_tbl[i]);
            if (i < 31) b = lt_fwd(b);
            else        b = b ^ rk_tbl[32];
        end
        return b;
    endfunction

    task automatic gen_keys(input logic [255:0] key);
        logic [31:0] w [0:139];
        for (int i = 0; i < 8; i++) w[i] = key[32*i +: 32];
        for (int i = 0; i < 132; i++)
            w[i+8] = rotl(w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ 32'h9E3779B9 ^ 32'(i), 11);
        for (int n = 0; n <= 32; n++)
            rk_tbl[n] = sbox_fwd((35 - n) % 8, {w[8+4*n], w[9+4*n], w[10+4*n], w[11+4*n]});
    endtask

    // Call at a negedge. Edges are numbered with the i_start-sampling edge as edge 1.
    task automatic run_dec(input logic [127:0] ct, input int stall_len, input logic log_idx,
                           output int edges, output logic [127:0] res);
        int           stalled;
        logic [127:0] hold;
        start = 1'b1;
        data  = ct;
        hold  = 128'h0;
        @(posedge clk); #1;
        start   = 1'b0;
        edges   = 1;
        stalled = 0;
        while (!valid && edges < 100) begin
            @(negedge clk);
            if (log_idx) check_val("rk_idx_seq", 128'(rk_idx), 128'(33 - edges));
            if (busy && rk_idx == 6'd10 && stalled < stall_len) begin
                rk_vld = 1'b0;
                if (stalled == 0) hold = dout;
                else check_val("stall_hold", dout, hold);
                stalled++;
            end else begin
                if (stall_len > 0 && stalled == stall_len && rk_idx == 6'd10)
                    check_val("stall_hold_end", dout, hold);
                rk_vld = 1'b1;
            end
            @(posedge clk); #1;
            edges++;
        end
        if (!valid) check_val("valid_timeout", 128'(valid), 128'd1);
        res = dout;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           edges;
        int           cnt;
        logic         seen;
        logic [127:0] res, pt, ct, pt2, ct2, hold;
        logic [255:0] key;

        rst    = 1'b1;
        start  = 1'b0;
        data   = 128'h0;
        rk_vld = 1'b1;
        ready  = 1'b1;
`ifdef SERPENT_DEC_ABORT_EN
        abort  = 1'b0;
`endif
        gen_keys(256'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy",  128'(busy),   128'd0);
        check_val("rst_valid", 128'(valid),  128'd0);
        check_val("rst_idx",   128'(rk_idx), 128'd0);
        check_val("rst_data",  dout,         128'd0);

        // Zero key, zero ciphertext; start on the first edge after reset release.
        rst = 1'b0;
        run_dec(128'h0, 0, 1'b1, edges, res);
        check_val("kat_latency",   128'(edges),  128'd34);
        check_val("kat_roundtrip", encrypt(res), 128'h0);
        @(posedge clk); #1;
        check_val("idle_idx",   128'(rk_idx), 128'd0);
        check_val("idle_busy",  128'(busy),   128'd0);
        check_val("idle_valid", 128'(valid),  128'd0);

        // Random key and plaintext, 5-cycle key stall at r=10.
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        gen_keys(key);
        pt = {$urandom, $urandom, $urandom, $urandom};
        ct = encrypt(pt);
        @(negedge clk);
        run_dec(ct, 5, 1'b0, edges, res);
        check_val("stall_latency", 128'(edges), 128'd39);
        check_val("stall_result",  res,         pt);
        @(posedge clk); #1;

        // Consumer back-pressure with a stray start while DONE.
        ready = 1'b0;
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        ct2 = encrypt(pt2);
        @(negedge clk);
        run_dec(ct2, 0, 1'b0, edges, res);
        check_val("bp_result", res, pt2);
        hold = dout;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b1;
            data  = ~ct2;
            @(posedge clk); #1;
            check_val("bp_valid_hold", 128'(valid), 128'd1);
            check_val("bp_data_hold",  dout,        hold);
        end
        @(negedge clk);
        start = 1'b0;
        ready = 1'b1;
        @(posedge clk); #1;
        check_val("bp_exit_busy",  128'(busy),  128'd0);
        check_val("bp_exit_valid", 128'(valid), 128'd0);
        check_val("bp_no_capture", dout,        pt2);

        // Asynchronous reset in the middle of round 20.
        @(negedge clk);
        start = 1'b1;
        data  = ct;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        while (rk_idx != 6'd20 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check_val("reach_r20", 128'(rk_idx), 128'd20);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_busy",  128'(busy),   128'd0);
        check_val("arst_valid", 128'(valid),  128'd0);
        check_val("arst_idx",   128'(rk_idx), 128'd0);
        check_val("arst_data",  dout,         128'd0);
        @(negedge clk);
        rst = 1'b0;
        run_dec(ct, 0, 1'b0, edges, res);
        check_val("post_rst_latency", 128'(edges), 128'd34);
        check_val("post_rst_result",  res,         pt);
        @(posedge clk); #1;

`ifdef SERPENT_DEC_ABORT_EN
        @(negedge clk);
        start = 1'b1;
        data  = ct;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        while (rk_idx != 6'd5 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check_val("reach_r5", 128'(rk_idx), 128'd5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_val("abort_busy", 128'(busy),   128'd0);
        check_val("abort_idx",  128'(rk_idx), 128'd0);
        check_val("abort_data", dout,         128'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        check_val("abort_no_valid", 128'(seen), 128'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
